// File: rtl/lvdc_pkg.sv
// Shared types and helpers for the duplex buffer register: FSM state encoding
// and the rule that routes memory modules onto channel A or B.
package lvdc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK1   = 2'd1,
      SHIFTING = 2'd2
   } state_t;

   localparam logic CHAN_A = 1'b0;
   localparam logic CHAN_B = 1'b1;

   // Even modules feed channel A, odd modules feed channel B.
   function automatic logic chan_of(input int m);
      return (m % 2 == 0) ? CHAN_A : CHAN_B;
   endfunction

endpackage

// File: rtl/br_channel.sv
// One channel of the duplex buffer register: clear/accumulate/load path,
// serial right shift and sticky parity check.
import lvdc_pkg::*;

module br_channel #(
   parameter int WIDTH   = 14,
   parameter int PAR_ODD = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v1,
   input  logic             busy,
   input  logic             shift_en,
   input  logic             chk_en,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] sa_or,
   input  logic             load,
   input  logic [WIDTH-2:0] tr,
   input  logic             par,
   output logic [WIDTH-1:0] br,
   output logic             perr
);

   localparam logic PAR_BIT = (PAR_ODD != 0);

   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] tr_word;

   assign base    = clr_n ? br : '0;
   assign tr_word = load ? {par, tr} : '0;

   // The load/clear path only runs when the FSM is idle; shift and check
   // strobes come from the FSM already qualified by V1.
   always_ff @(posedge clk) begin
      if (reset) begin
         br   <= '0;
         perr <= 1'b0;
      end else if (shift_en) begin
         br <= {1'b0, br[WIDTH-1:1]};
      end else if (chk_en) begin
         perr <= perr | ((^br) != PAR_BIT);
      end else if (v1 && !busy) begin
         br <= base | sa_or | tr_word;
         if (!clr_n)
            perr <= 1'b0;
      end
   end

endmodule

// File: rtl/duplex_buffer_register.sv
// Duplex buffer register top: module routing, check/shift FSM with its bit
// counter, A/B miscompare flag and the complemented register outputs.
import lvdc_pkg::*;

module duplex_buffer_register #(
   parameter int WIDTH   = 14,
   parameter int NMOD    = 8,
   parameter int PAR_ODD = 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  V1,
   input  logic                  CBRN_A,
   input  logic                  CBRN_B,
   input  logic [NMOD*WIDTH-1:0] SA,
   input  logic [NMOD-1:0]       SA_EN,
   input  logic [WIDTH-2:0]      TR_A,
   input  logic [WIDTH-2:0]      TR_B,
   input  logic                  SBRX_A,
   input  logic                  SBRX_B,
   input  logic                  PAR_A,
   input  logic                  PAR_B,
   input  logic                  CHECK,
   input  logic                  SHIFT,
   output logic [WIDTH-1:0]      BRA,
   output logic [WIDTH-1:0]      BRA_N,
   output logic [WIDTH-1:0]      BRB,
   output logic [WIDTH-1:0]      BRB_N,
   output logic                  PERR_A,
   output logic                  PERR_B,
   output logic                  MISCMP,
   output logic                  SER_A,
   output logic                  SER_B,
   output logic                  BUSY,
   output logic [1:0]            DBG_STATE
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            chk_en, shift_en;
   logic [WIDTH-1:0] sa_a, sa_b;

   always_comb begin
      sa_a = '0;
      sa_b = '0;
      for (int m = 0; m < NMOD; m++) begin
         if (SA_EN[m]) begin
            if (chan_of(m) == CHAN_A)
               sa_a = sa_a | SA[m*WIDTH +: WIDTH];
            else
               sa_b = sa_b | SA[m*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // CHECK has priority over SHIFT; both are ignored outside IDLE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      chk_en   = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (V1 && CHECK) begin
               state_d = CHECK1;
            end else if (V1 && SHIFT) begin
               state_d = SHIFTING;
               cnt_d   = CW'(WIDTH);
            end
         end
         CHECK1: begin
            chk_en = V1;
            if (V1)
               state_d = IDLE;
         end
         SHIFTING: begin
            shift_en = V1;
            if (V1) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1))
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign BUSY      = (state_q != IDLE);
   assign DBG_STATE = state_q;

   br_channel #(.WIDTH(WIDTH), .PAR_ODD(PAR_ODD)) u_chan_a (
      .clk(CLK), .reset(RESET), .v1(V1), .busy(BUSY),
      .shift_en(shift_en), .chk_en(chk_en), .clr_n(CBRN_A),
      .sa_or(sa_a), .load(SBRX_A), .tr(TR_A), .par(PAR_A),
      .br(BRA), .perr(PERR_A)
   );

   br_channel #(.WIDTH(WIDTH), .PAR_ODD(PAR_ODD)) u_chan_b (
      .clk(CLK), .reset(RESET), .v1(V1), .busy(BUSY),
      .shift_en(shift_en), .chk_en(chk_en), .clr_n(CBRN_B),
      .sa_or(sa_b), .load(SBRX_B), .tr(TR_B), .par(PAR_B),
      .br(BRB), .perr(PERR_B)
   );

   // Parity bit is excluded from the miscompare; a double clear resets it.
   always_ff @(posedge CLK) begin
      if (RESET)
         MISCMP <= 1'b0;
      else if (chk_en)
         MISCMP <= MISCMP | (BRA[WIDTH-2:0] != BRB[WIDTH-2:0]);
      else if (V1 && !BUSY && !CBRN_A && !CBRN_B)
         MISCMP <= 1'b0;
   end

   assign BRA_N = ~BRA;
   assign BRB_N = ~BRB;
   assign SER_A = (state_q == SHIFTING) & BRA[0];
   assign SER_B = (state_q == SHIFTING) & BRB[0];

endmodule

// File: tb/tb_duplex_buffer_register.sv
// Directed bench for duplex_buffer_register (WIDTH=14, NMOD=8, PAR_ODD=1):
// load/clear/accumulate, parity and miscompare checks, serial shift, reset.
`timescale 1ns/1ps

module tb_duplex_buffer_register;

   localparam int W = 14;
   localparam int N = 8;

   logic           CLK = 1'b0;
   logic           RESET, V1, CBRN_A, CBRN_B;
   logic [N*W-1:0] SA;
   logic [N-1:0]   SA_EN;
   logic [W-2:0]   TR_A, TR_B;
   logic           SBRX_A, SBRX_B, PAR_A, PAR_B, CHECK, SHIFT;
   logic [W-1:0]   BRA, BRA_N, BRB, BRB_N;
   logic           PERR_A, PERR_B, MISCMP, SER_A, SER_B, BUSY;
   logic [1:0]     DBG_STATE;

   int passed = 0;
   int total  = 0;

   duplex_buffer_register #(.WIDTH(W), .NMOD(N), .PAR_ODD(1)) dut (
      .CLK(CLK), .RESET(RESET), .V1(V1), .CBRN_A(CBRN_A), .CBRN_B(CBRN_B),
      .SA(SA), .SA_EN(SA_EN), .TR_A(TR_A), .TR_B(TR_B),
      .SBRX_A(SBRX_A), .SBRX_B(SBRX_B), .PAR_A(PAR_A), .PAR_B(PAR_B),
      .CHECK(CHECK), .SHIFT(SHIFT),
      .BRA(BRA), .BRA_N(BRA_N), .BRB(BRB), .BRB_N(BRB_N),
      .PERR_A(PERR_A), .PERR_B(PERR_B), .MISCMP(MISCMP),
      .SER_A(SER_A), .SER_B(SER_B), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
   );

   always #5 CLK = ~CLK;

   task automatic idle_inputs();
      V1 = 1'b0; CBRN_A = 1'b1; CBRN_B = 1'b1;
      SA = '0; SA_EN = '0; TR_A = '0; TR_B = '0;
      SBRX_A = 1'b0; SBRX_B = 1'b0; PAR_A = 1'b0; PAR_B = 1'b0;
      CHECK = 1'b0; SHIFT = 1'b0;
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled there too.
   task automatic strobe();
      V1 = 1'b1;
      @(posedge CLK); #1;
      idle_inputs();
   endtask

   task automatic no_strobe();
      @(posedge CLK); #1;
      idle_inputs();
   endtask

   task automatic set_sa(input int m, input logic [W-1:0] val);
      SA[m*W +: W] = val;
      SA_EN[m] = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   logic [W-1:0] pat_a, pat_b;

   initial begin
      idle_inputs();
      RESET = 1'b1;
      no_strobe(); no_strobe();
      RESET = 1'b0;

      chk("rst_bra", BRA, 0);      chk("rst_brb", BRB, 0);
      chk("rst_bra_n", BRA_N, 14'h3FFF); chk("rst_brb_n", BRB_N, 14'h3FFF);
      chk("rst_perr_a", PERR_A, 0); chk("rst_perr_b", PERR_B, 0);
      chk("rst_miscmp", MISCMP, 0); chk("rst_ser_a", SER_A, 0);
      chk("rst_ser_b", SER_B, 0);   chk("rst_busy", BUSY, 0);
      chk("rst_state", DBG_STATE, 0);

      // Clear A, then sense module 2 into A
      CBRN_A = 1'b0; strobe();
      set_sa(2, 14'h0005); strobe();
      chk("sa2_bra", BRA, 14'h0005); chk("sa2_brb", BRB, 0);
      chk("sa2_bra_n", BRA_N, 14'h3FFA);

      // Accumulation across V1 strobes, then clear-then-OR
      CBRN_A = 1'b0; strobe();
      set_sa(0, 14'h0001); strobe();
      set_sa(4, 14'h0100); strobe();
      chk("accum_bra", BRA, 14'h0101);
      CBRN_A = 1'b0; set_sa(0, 14'h0002); strobe();
      chk("clr_or_bra", BRA, 14'h0002);
      set_sa(3, 14'h0040); strobe();
      chk("odd_brb", BRB, 14'h0040); chk("odd_bra", BRA, 14'h0002);
      set_sa(0, 14'h0010); no_strobe();
      chk("nov1_hold", BRA, 14'h0002);

      // Parity: 14'h1234 has odd weight, no error; BRB=0 has even weight
      CBRN_A = 1'b0; CBRN_B = 1'b0; strobe();
      SBRX_A = 1'b1; TR_A = 13'h1234; strobe();
      chk("load_bra", BRA, 14'h1234);
      CHECK = 1'b1; strobe();
      chk("chk_busy", BUSY, 1); chk("chk_state", DBG_STATE, 1);
      strobe();
      chk("par_ok_a", PERR_A, 0); chk("par_bad_b", PERR_B, 1);
      chk("miscmp_1234", MISCMP, 1); chk("chk_done", BUSY, 0);
      CBRN_A = 1'b0; SBRX_A = 1'b1; TR_A = 13'h1235; strobe();
      CHECK = 1'b1; strobe(); strobe();
      chk("par_bad_a", PERR_A, 1);
      strobe();
      chk("perr_sticky", PERR_A, 1);
      CBRN_A = 1'b0; strobe();
      chk("perr_clr_a", PERR_A, 0); chk("miscmp_keep", MISCMP, 1);
      chk("perr_keep_b", PERR_B, 1);
      CBRN_A = 1'b0; CBRN_B = 1'b0; strobe();
      chk("miscmp_clr", MISCMP, 0); chk("perr_clr_b", PERR_B, 0);

      // Miscompare 3 vs 2; CBRN and SHIFT ignored while in CHECK1
      CBRN_A = 1'b0; CBRN_B = 1'b0; set_sa(0, 14'h0003); set_sa(1, 14'h0002); strobe();
      CHECK = 1'b1; strobe();
      chk("mis_busy", BUSY, 1);
      CBRN_A = 1'b0; SHIFT = 1'b1; strobe();
      chk("mis_flag", MISCMP, 1); chk("mis_busy_drop", BUSY, 0);
      chk("mis_clr_ignored", BRA, 14'h0003); chk("mis_shift_ignored", DBG_STATE, 0);
      chk("mis_perr_a", PERR_A, 1); chk("mis_perr_b", PERR_B, 0);
      CBRN_A = 1'b0; CBRN_B = 1'b0; strobe();
      chk("mis_clr", MISCMP, 0);

      // Parity bit difference alone is not a miscompare
      set_sa(0, 14'h2000); CHECK = 1'b1; SHIFT = 1'b1; strobe();
      chk("chk_beats_shift", DBG_STATE, 1);
      strobe();
      chk("par_only_mis", MISCMP, 0); chk("par_only_perr_a", PERR_A, 0);
      chk("par_only_perr_b", PERR_B, 1);

      // Serial read-out of BRB=14'h2005 and BRA=14'h0001
      CBRN_A = 1'b0; CBRN_B = 1'b0; set_sa(0, 14'h0001); set_sa(1, 14'h2005); strobe();
      chk("pre_shift_ser", SER_B, 0);
      SHIFT = 1'b1; strobe();
      chk("shift_state", DBG_STATE, 2);
      pat_a = 14'h0001; pat_b = 14'h2005;
      for (int i = 0; i < W; i++) begin
         chk($sformatf("ser_b_%0d", i), SER_B, pat_b[i]);
         chk($sformatf("ser_a_%0d", i), SER_A, pat_a[i]);
         chk($sformatf("shift_busy_%0d", i), BUSY, 1);
         SBRX_B = 1'b1; TR_B = 13'h1FFF; CBRN_A = 1'b0; CHECK = 1'b1;
         strobe();
      end
      chk("shift_brb_end", BRB, 0); chk("shift_bra_end", BRA, 0);
      chk("shift_busy_end", BUSY, 0); chk("shift_ser_end", SER_B, 0);

      // Reset partway through a shift (7 bits remaining)
      set_sa(0, 14'h00F0); set_sa(1, 14'h3F00); strobe();
      CHECK = 1'b1; strobe(); strobe();
      chk("pre_rst_perr_a", PERR_A, 1);
      SHIFT = 1'b1; strobe();
      repeat (7) strobe();
      chk("mid_shift_busy", BUSY, 1); chk("mid_shift_brb", BRB, 14'h007E);
      RESET = 1'b1; V1 = 1'b1; SHIFT = 1'b1;
      @(posedge CLK); #1;
      idle_inputs();
      chk("mrst_bra", BRA, 0);  chk("mrst_brb", BRB, 0);
      chk("mrst_bra_n", BRA_N, 14'h3FFF); chk("mrst_brb_n", BRB_N, 14'h3FFF);
      chk("mrst_perr_a", PERR_A, 0); chk("mrst_miscmp", MISCMP, 0);
      chk("mrst_ser", SER_B, 0); chk("mrst_busy", BUSY, 0);
      chk("mrst_state", DBG_STATE, 0);
      RESET = 1'b0;
      no_strobe();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
